// File: rtl/alu_pkg.sv
// Shared encodings for the CB-prefix BIT/RES/SET micro-sequencer.
// ALU control line layout, per-op constants and sequencer states.
package alu_pkg;

  typedef struct packed {
    logic [2:0] bs;
    logic [7:0] op;
    logic [1:0] sh;
    logic [1:0] oe;
    logic       la;
    logic       lb;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } alu_line_t;

  localparam logic [1:0] OE_NONE = 2'd0;
  localparam logic [1:0] BS_OE   = 2'd1;
  localparam logic [1:0] SH_OE   = 2'd2;
  localparam logic [1:0] RES_OE  = 2'd3;

  localparam logic BUS_LD = 1'b1;
  localparam logic NO_LD  = 1'b0;

  localparam logic [1:0] NO_SH = 2'd0;

  localparam alu_line_t ALU_NOP = '0;

  typedef enum logic [1:0] {
    BITOP_BIT = 2'b01,
    BITOP_RES = 2'b10,
    BITOP_SET = 2'b11
  } bitop_e;

  // {r,s,v,ne,ci}
  typedef struct packed {
    logic r;
    logic s;
    logic v;
    logic ne;
    logic ci;
  } bitop_k_t;

  localparam bitop_k_t BITOP_SET_L1 = 5'b11100;
  localparam bitop_k_t BITOP_SET_L2 = 5'b11100;
  localparam bitop_k_t BITOP_RES_L1 = 5'b10110;
  localparam bitop_k_t BITOP_RES_L2 = 5'b10110;
  localparam bitop_k_t BITOP_BIT_L1 = 5'b00100;
  localparam bitop_k_t BITOP_BIT_L2 = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L0,
    S_L1,
    S_L2,
    S_DONE
  } state_e;

  function automatic bitop_k_t bitop_k(
    input bitop_e k,
    input logic   l2
  );
    bitop_k_t p;
    unique case (k)
      BITOP_SET: p = l2 ? BITOP_SET_L2 : BITOP_SET_L1;
      BITOP_RES: p = l2 ? BITOP_RES_L2 : BITOP_RES_L1;
      default:   p = l2 ? BITOP_BIT_L2 : BITOP_BIT_L1;
    endcase
    return p;
  endfunction

  function automatic alu_line_t ctl_sel(
    input logic [2:0] b
  );
    alu_line_t c;
    c    = ALU_NOP;
    c.bs = b;
    c.oe = BS_OE;
    c.lb = BUS_LD;
    return c;
  endfunction

  function automatic alu_line_t ctl_run(
    input bitop_e     k,
    input logic [7:0] a,
    input logic       l2
  );
    alu_line_t c;
    bitop_k_t  p;
    c    = ALU_NOP;
    p    = bitop_k(k, l2);
    c.r  = p.r;
    c.s  = p.s;
    c.v  = p.v;
    c.ne = p.ne;
    c.ci = p.ci;
    c.la = NO_LD;
    c.lb = NO_LD;
    if (!l2) begin
      c.op = a;
      c.sh = NO_SH;
      c.oe = SH_OE;
      c.la = BUS_LD;
      c.l  = 1'b1;
      c.h  = 1'b0;
    end else begin
      c.oe = RES_OE;
      c.l  = 1'b0;
      c.h  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_bitop_seq_if.sv
// Request/response bundle between the CB-op issuer and the sequencer.
// master = issuer side, slave = sequencer side.
interface alu_bitop_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [3:0] flags_in;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_we;
  logic [2:0] out_reg;
  logic [3:0] out_flags;
  logic       illegal;

  modport master (
    output in_valid, opcode, operand, flags_in,
    input  in_ready, out_valid, out_data,
    input  out_we, out_reg, out_flags, illegal
  );

  modport slave (
    input  in_valid, opcode, operand, flags_in,
    output in_ready, out_valid, out_data,
    output out_we, out_reg, out_flags, illegal
  );
endinterface

// File: rtl/alu_bitop_seq_dec.sv
// CB opcode decoder: op class, bit index, register index.
// opcode[7:6]==00 is not a bit op and is flagged illegal.
module alu_bitop_seq_dec
  import alu_pkg::*;
(
  input  logic [7:0] opcode,
  output bitop_e     kind,
  output logic [2:0] bit_sel,
  output logic [2:0] reg_sel,
  output logic       illegal
);

  assign bit_sel = opcode[5:3];
  assign reg_sel = opcode[2:0];

  always_comb begin
    kind    = BITOP_BIT;
    illegal = 1'b0;
    unique case (1'b1)
      (opcode[7:6] == 2'b01): kind = BITOP_BIT;
      (opcode[7:6] == 2'b10): kind = BITOP_RES;
      (opcode[7:6] == 2'b11): kind = BITOP_SET;
      default:                illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_bitop_seq.sv
// BIT/RES/SET micro-sequencer driving the ALU control line for 3 cycles.
// ALU_BITOP_OVERLAP_EN: accept a new op in DONE (issue every 4 cycles).
module alu_bitop_seq
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            nreset,
  alu_bitop_seq_if.slave  bus,
  output alu_line_t       alu_ctl,
  input  logic [7:0]      alu_result,
  input  logic            alu_zero
);

  state_e     state;
  bitop_e     kind_q;
  logic [7:0] opnd_q;
  logic [3:0] flg_q;
  logic [2:0] reg_q;

  logic       out_valid;
  logic [7:0] out_data;
  logic       out_we;
  logic [2:0] out_reg;
  logic [3:0] out_flags;
  logic       illegal;

  bitop_e     d_kind;
  logic [2:0] d_bit;
  logic [2:0] d_reg;
  logic       d_ill;
  logic       in_ready;
  logic       accept;

  alu_bitop_seq_dec u_dec (
    .opcode  (bus.opcode),
    .kind    (d_kind),
    .bit_sel (d_bit),
    .reg_sel (d_reg),
    .illegal (d_ill)
  );

`ifdef ALU_BITOP_OVERLAP_EN
  assign in_ready = (state == S_IDLE) || (state == S_DONE);
`else
  assign in_ready = (state == S_IDLE);
`endif

  assign accept = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_we    = out_we;
  assign bus.out_reg   = out_reg;
  assign bus.out_flags = out_flags;
  assign bus.illegal   = illegal;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      alu_ctl   <= ALU_NOP;
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      illegal   <= 1'b0;
      out_data  <= 8'h00;
      out_flags <= 4'h0;
      out_reg   <= 3'd0;
      kind_q    <= BITOP_BIT;
      opnd_q    <= 8'h00;
      flg_q     <= 4'h0;
      reg_q     <= 3'd0;
    end else begin
      out_valid <= 1'b0;
      alu_ctl   <= ALU_NOP;
      unique case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
            kind_q <= d_kind;
            opnd_q <= bus.operand;
            flg_q  <= bus.flags_in;
            reg_q  <= d_reg;
            if (d_ill) begin
              // Nothing to compute: report straight away.
              state     <= S_DONE;
              out_valid <= 1'b1;
              illegal   <= 1'b1;
              out_we    <= 1'b0;
              out_data  <= 8'h00;
              out_flags <= bus.flags_in;
              out_reg   <= d_reg;
            end else begin
              state   <= S_L0;
              alu_ctl <= ctl_sel(d_bit);
            end
          end
        end
        S_L0: begin
          state   <= S_L1;
          alu_ctl <= ctl_run(kind_q, opnd_q, 1'b0);
        end
        S_L1: begin
          state   <= S_L2;
          alu_ctl <= ctl_run(kind_q, opnd_q, 1'b1);
        end
        S_L2: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          illegal   <= 1'b0;
          out_reg   <= reg_q;
          if (kind_q == BITOP_BIT) begin
            out_data  <= opnd_q;
            out_we    <= 1'b0;
            out_flags <= {alu_zero, 1'b0, 1'b1, flg_q[0]};
          end else begin
            out_data  <= alu_result;
            out_we    <= 1'b1;
            out_flags <= flg_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
